// File: rtl/sys_mem_sram_pkg.sv
// Shared types for the system-memory to async-SRAM bridge: FSM states,
// SRAM geometry and the halfword phase encoding.
package sys_mem_sram_pkg;

    localparam int SRAM_DATA_W = 16;
    localparam int SRAM_ADDR_W = 18;

    localparam logic PHASE_LO = 1'b0;
    localparam logic PHASE_HI = 1'b1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_LO   = 3'd1,
        WR_HI   = 3'd2,
        RD_LO   = 3'd3,
        RD_HI   = 3'd4,
        RD_DONE = 3'd5
    } sram_fsm_t;

    function automatic logic fsm_is_wr(input sram_fsm_t s);
        return (s == WR_LO) || (s == WR_HI);
    endfunction

    function automatic logic fsm_is_rd(input sram_fsm_t s);
        return (s == RD_LO) || (s == RD_HI);
    endfunction

    function automatic logic fsm_phase(input sram_fsm_t s);
        return ((s == WR_HI) || (s == RD_HI)) ? PHASE_HI : PHASE_LO;
    endfunction

endpackage

// File: rtl/sys_mem_sram_cntrlr.sv
// Splits 32-bit word requests into two 16-bit async-SRAM phases; read data strobes at T+2*ACC+1.
// Backpressure via cntrlr_wait, high from the cycle after accept until the FSM is back in IDLE.
module sys_mem_sram_cntrlr #(
    parameter int MEM_DATA_W      = 32,
    parameter int MEM_ADDR_W      = 27,
    parameter int SRAM_DATA_W     = 16,
    parameter int SRAM_ADDR_W     = 18,
    parameter int SRAM_ACC_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   cntrlr_wait,
    input  logic                   cntrlr_wren,
    input  logic                   cntrlr_rden,
    input  logic [MEM_ADDR_W-1:0]  cntrlr_addr,
    input  logic [MEM_DATA_W-1:0]  cntrlr_wdata,
    output logic                   cntrlr_rd_valid,
    output logic [MEM_DATA_W-1:0]  cntrlr_rdata,
    output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
    inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ,
    output logic                   SRAM_CE_N,
    output logic                   SRAM_OE_N,
    output logic                   SRAM_WE_N,
    output logic                   SRAM_UB_N,
    output logic                   SRAM_LB_N
);
    import sys_mem_sram_pkg::*;

    localparam int CNT_W   = $clog2(SRAM_ACC_CYCLES);
    localparam int WORD_AW = SRAM_ADDR_W - 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SRAM_ACC_CYCLES - 1);

    generate
        if (SRAM_ACC_CYCLES < 2) begin : g_acc_chk
            $error("SRAM_ACC_CYCLES must be at least 2");
        end
        if (MEM_DATA_W != 2 * SRAM_DATA_W) begin : g_width_chk
            $error("MEM_DATA_W must equal 2*SRAM_DATA_W");
        end
    endgenerate

    sram_fsm_t               state, state_nxt;
    logic [CNT_W-1:0]        cnt, cnt_nxt;
    logic [WORD_AW-1:0]      addr_lat;
    logic [MEM_DATA_W-1:0]   wdata_lat;
    logic [SRAM_DATA_W-1:0]  lo_q;
    logic [SRAM_DATA_W-1:0]  dq_out;
    logic                    dq_oe;

    logic                    accept;
    logic                    phase_last;
    logic [WORD_AW-1:0]      word_addr;
    logic [MEM_DATA_W-1:0]   word_data;
    logic                    nxt_wr;
    logic                    nxt_rd;
    logic                    nxt_phase;

    // Word-address bits above the SRAM depth alias by design.
    logic unused_addr_hi;
    assign unused_addr_hi = ^cntrlr_addr[MEM_ADDR_W-1:WORD_AW];

    assign SRAM_DQ = dq_oe ? dq_out : {SRAM_DATA_W{1'bz}};

    assign accept     = (state == IDLE) && (cntrlr_wren || cntrlr_rden);
    assign phase_last = (cnt == CNT_LAST);
    // In IDLE the first phase is launched straight from the request bus.
    assign word_addr  = (state == IDLE) ? cntrlr_addr[WORD_AW-1:0] : addr_lat;
    assign word_data  = (state == IDLE) ? cntrlr_wdata : wdata_lat;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = '0;
        unique case (state)
            IDLE: begin
                if (cntrlr_wren)      state_nxt = WR_LO;
                else if (cntrlr_rden) state_nxt = RD_LO;
            end
            WR_LO: begin
                if (phase_last) state_nxt = WR_HI;
                else            cnt_nxt   = cnt + CNT_W'(1);
            end
            WR_HI: begin
                if (phase_last) state_nxt = IDLE;
                else            cnt_nxt   = cnt + CNT_W'(1);
            end
            RD_LO: begin
                if (phase_last) state_nxt = RD_HI;
                else            cnt_nxt   = cnt + CNT_W'(1);
            end
            RD_HI: begin
                if (phase_last) state_nxt = RD_DONE;
                else            cnt_nxt   = cnt + CNT_W'(1);
            end
            RD_DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        nxt_wr    = fsm_is_wr(state_nxt);
        nxt_rd    = fsm_is_rd(state_nxt);
        nxt_phase = fsm_phase(state_nxt);
    end

    // Pins are registered from the next state so every output is a flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            cnt             <= '0;
            addr_lat        <= '0;
            wdata_lat       <= '0;
            lo_q            <= '0;
            cntrlr_wait     <= 1'b0;
            cntrlr_rd_valid <= 1'b0;
            cntrlr_rdata    <= '0;
            SRAM_ADDR       <= '0;
            SRAM_CE_N       <= 1'b1;
            SRAM_OE_N       <= 1'b1;
            SRAM_WE_N       <= 1'b1;
            SRAM_UB_N       <= 1'b1;
            SRAM_LB_N       <= 1'b1;
            dq_oe           <= 1'b0;
            dq_out          <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                addr_lat  <= cntrlr_addr[WORD_AW-1:0];
                wdata_lat <= cntrlr_wdata;
            end
            if ((state == RD_LO) && phase_last) lo_q <= SRAM_DQ;
            if ((state == RD_HI) && phase_last) cntrlr_rdata <= {SRAM_DQ, lo_q};

            cntrlr_wait     <= (state_nxt != IDLE);
            cntrlr_rd_valid <= (state_nxt == RD_DONE);

            SRAM_ADDR <= (nxt_wr || nxt_rd) ? {word_addr, nxt_phase} : '0;
            SRAM_CE_N <= !(nxt_wr || nxt_rd);
            SRAM_UB_N <= !(nxt_wr || nxt_rd);
            SRAM_LB_N <= !(nxt_wr || nxt_rd);
            SRAM_OE_N <= !nxt_rd;
            // Last cycle of a write phase releases WE_N to hold address/data.
            SRAM_WE_N <= !(nxt_wr && (cnt_nxt != CNT_LAST));
            dq_oe     <= nxt_wr;
            dq_out    <= (nxt_phase == PHASE_HI) ? word_data[MEM_DATA_W-1:SRAM_DATA_W]
                                                 : word_data[SRAM_DATA_W-1:0];
        end
    end

endmodule

// File: tb/tb_sys_mem_sram_cntrlr.sv
// Bench for sys_mem_sram_cntrlr with a behavioural async SRAM on the pins;
// table-driven word requests plus hand sequences for back-to-back and mid-read reset.
module tb_sys_mem_sram_cntrlr;

    logic        clk = 1'b0;
    logic        rst;
    logic        wren, rden;
    logic [26:0] addr;
    logic [31:0] wdata;
    logic        wait_o, rd_valid;
    logic [31:0] rdata;
    logic [17:0] sram_addr;
    wire  [15:0] sram_dq;
    logic        ce_n, oe_n, we_n, ub_n, lb_n;

    always #5 clk = ~clk;

    sys_mem_sram_cntrlr #(
        .MEM_DATA_W(32), .MEM_ADDR_W(27), .SRAM_DATA_W(16),
        .SRAM_ADDR_W(18), .SRAM_ACC_CYCLES(2)
    ) dut (
        .clk(clk), .rst(rst), .cntrlr_wait(wait_o),
        .cntrlr_wren(wren), .cntrlr_rden(rden), .cntrlr_addr(addr),
        .cntrlr_wdata(wdata), .cntrlr_rd_valid(rd_valid), .cntrlr_rdata(rdata),
        .SRAM_ADDR(sram_addr), .SRAM_DQ(sram_dq), .SRAM_CE_N(ce_n),
        .SRAM_OE_N(oe_n), .SRAM_WE_N(we_n), .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n)
    );

    // Behavioural async SRAM
    logic [15:0] mem [0:(1<<18)-1];
    assign sram_dq = (!ce_n && !oe_n && we_n) ? mem[sram_addr] : 16'hzzzz;
    always @(posedge clk) if (!ce_n && !we_n) mem[sram_addr] <= sram_dq;

    int errs = 0;
    int checks = 0;
    int rdv_total = 0;
    int contention = 0;
    int ublb_bad = 0;

    always @(negedge clk) begin
        if (rd_valid) rdv_total++;
        if (!oe_n && !we_n) contention++;
        if ((ub_n !== ce_n) || (lb_n !== ce_n)) ublb_bad++;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, got, exp);
        end
    endtask

    task automatic do_req(input logic w, input logic r, input logic [26:0] a, input logic [31:0] d,
                          output int nvalid, output logic [31:0] rd, output int wcyc,
                          output int lat, output int we_low, output int oe_low, output bit tmo);
        wren = w; rden = r; addr = a; wdata = d;
        nvalid = 0; rd = '0; wcyc = 0; lat = 0; we_low = 0; oe_low = 0; tmo = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (rd_valid) begin nvalid++; rd = rdata; lat = c; end
            if (!we_n) we_low++;
            if (!oe_n) oe_low++;
            if (wait_o) wcyc++;
            else begin
                wren = 1'b0; rden = 1'b0; tmo = 1'b0;
                break;
            end
        end
        wren = 1'b0; rden = 1'b0;
    endtask

    typedef struct {
        logic        w;
        logic        r;
        logic [26:0] a;
        logic [31:0] d;
        int          exp_rd;
        logic [31:0] exp_data;
        int          exp_wait;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int nv, wc, lt, wl, ol;
        logic [31:0] rd;
        bit tmo;
        logic [31:0] last_rd;
        int exp_rdv;

        vecs[0] = '{1'b1, 1'b0, 27'h0000010, 32'hCAFEF00D, 0, 32'h0,        4};
        vecs[1] = '{1'b0, 1'b1, 27'h0000010, 32'h0,        1, 32'hCAFEF00D, 5};
        vecs[2] = '{1'b1, 1'b1, 27'h0000003, 32'h12345678, 0, 32'h0,        4};
        vecs[3] = '{1'b0, 1'b1, 27'h0000003, 32'h0,        1, 32'h12345678, 5};
        vecs[4] = '{1'b1, 1'b0, 27'h0020001, 32'hDEADBEEF, 0, 32'h0,        4};
        vecs[5] = '{1'b0, 1'b1, 27'h0000001, 32'h0,        1, 32'hDEADBEEF, 5};
        vecs[6] = '{1'b0, 1'b1, 27'h0020010, 32'h0,        1, 32'hCAFEF00D, 5};

        last_rd = '0;
        exp_rdv = 0;
        rst = 1'b1; wren = 1'b0; rden = 1'b0; addr = '0; wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset wait", {31'b0, wait_o}, 32'd0);
        chk("reset rd_valid", {31'b0, rd_valid}, 32'd0);
        chk("reset rdata", rdata, 32'h0);
        chk("reset sram_addr", {14'b0, sram_addr}, 32'h0);
        chk("reset controls", {27'b0, ce_n, oe_n, we_n, ub_n, lb_n}, 32'h1F);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) begin
            do_req(vecs[i].w, vecs[i].r, vecs[i].a, vecs[i].d, nv, rd, wc, lt, wl, ol, tmo);
            chk($sformatf("v%0d timeout", i), {31'b0, tmo}, 32'd0);
            chk($sformatf("v%0d wait cycles", i), wc, vecs[i].exp_wait);
            chk($sformatf("v%0d rd_valid pulses", i), nv, vecs[i].exp_rd);
            if (vecs[i].exp_rd != 0) begin
                chk($sformatf("v%0d rdata", i), rd, vecs[i].exp_data);
                chk($sformatf("v%0d rd latency", i), lt, 32'd5);
                chk($sformatf("v%0d oe_n low cycles", i), ol, 32'd4);
                chk($sformatf("v%0d we_n low cycles", i), wl, 32'd0);
                last_rd = vecs[i].exp_data;
                exp_rdv++;
            end else begin
                chk($sformatf("v%0d we_n low cycles", i), wl, 32'd2);
                chk($sformatf("v%0d oe_n low cycles", i), ol, 32'd0);
                chk($sformatf("v%0d rdata held", i), rdata, last_rd);
            end
            @(posedge clk); #1;
        end

        chk("mem 0x00020", {16'b0, mem[18'h00020]}, 32'hF00D);
        chk("mem 0x00021", {16'b0, mem[18'h00021]}, 32'hCAFE);
        chk("mem 0x00006", {16'b0, mem[18'h00006]}, 32'h5678);
        chk("mem 0x00007", {16'b0, mem[18'h00007]}, 32'h1234);
        chk("mem 0x00002", {16'b0, mem[18'h00002]}, 32'hBEEF);
        chk("mem 0x00003", {16'b0, mem[18'h00003]}, 32'hDEAD);

        // Back-to-back: write held through wait, read issued as wait falls
        wren = 1'b1; rden = 1'b0; addr = 27'h1; wdata = 32'hAAAA5555;
        tmo = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (c > 1 && !wait_o) begin tmo = 1'b0; break; end
        end
        chk("b2b write timeout", {31'b0, tmo}, 32'd0);
        do_req(1'b0, 1'b1, 27'h1, 32'h0, nv, rd, wc, lt, wl, ol, tmo);
        chk("b2b read timeout", {31'b0, tmo}, 32'd0);
        chk("b2b read wait cycles", wc, 32'd5);
        chk("b2b read pulses", nv, 32'd1);
        chk("b2b read rdata", rd, 32'hAAAA5555);
        chk("b2b read latency", lt, 32'd5);
        last_rd = 32'hAAAA5555;
        exp_rdv++;
        @(posedge clk); #1;

        // Reset asserted during T+2 of a read
        rden = 1'b1; addr = 27'h10;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1; rden = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort controls", {27'b0, ce_n, oe_n, we_n, ub_n, lb_n}, 32'h1F);
        chk("abort wait", {31'b0, wait_o}, 32'd0);
        chk("abort rd_valid", {31'b0, rd_valid}, 32'd0);
        chk("abort rdata", rdata, 32'h0);
        repeat (10) @(posedge clk);
        #1;
        chk("abort no rd_valid", rdv_total, exp_rdv);

        do_req(1'b0, 1'b1, 27'h1, 32'h0, nv, rd, wc, lt, wl, ol, tmo);
        chk("post-reset read timeout", {31'b0, tmo}, 32'd0);
        chk("post-reset read pulses", nv, 32'd1);
        chk("post-reset read rdata", rd, 32'hAAAA5555);
        exp_rdv++;
        repeat (3) @(posedge clk);
        #1;

        chk("total rd_valid pulses", rdv_total, exp_rdv);
        chk("oe_n/we_n overlap cycles", contention, 32'd0);
        chk("ub_n/lb_n vs ce_n mismatches", ublb_bad, 32'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errs + 1);
        $fatal(1, "watchdog");
    end

endmodule
